hack_exec_unit: RTL



---
 rtl/hack_exec_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hack_exec_unit.sv
// Multi-cycle fetch/execute controller for the Hack CPU: owns A, D, PC and IR,
// sequences instruction/data memory handshakes and drives an external combinational ALU.
module hack_exec_unit #(
  parameter int PC_W = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            instr_req,
  output logic [PC_W-1:0] instr_addr,
  input  logic            instr_valid,
  input  logic [15:0]     instr,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [PC_W-1:0] addressM,
  output logic [15:0]     outM,
  input  logic [15:0]     inM,
  input  logic            mem_ready,
  output logic [15:0]     alu_x,
  output logic [15:0]     alu_y,
  output logic            zx,
  output logic            nx,
  output logic            zy,
  output logic            ny,
  output logic            f,
  output logic            no,
  input  logic [15:0]     alu_out,
  input  logic            zr,
  input  logic            ng,
  output logic [PC_W-1:0] pc
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_EXEC,
    S_MEMWR
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = 1;

  state_t          state, state_nxt;
  logic            run;
  logic [15:0]     a_reg, d_reg, ir, mbr, wr_data;
  logic [PC_W-1:0] pc_reg, wr_addr, pc_inc;
  logic            jmp;

  assign pc_inc     = pc_reg + PC_ONE;
  assign jmp        = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);
  assign pc         = pc_reg;
  assign instr_addr = pc_reg;
  assign outM       = wr_data;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    instr_req = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    addressM  = '0;
    alu_x     = '0;
    alu_y     = '0;
    {zx, nx, zy, ny, f, no} = 6'b0;
    case (state)
      S_FETCH: begin
        // run holds off the first request until one clock after reset release
        instr_req = run;
        if (run && instr_valid) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (!ir[15])    state_nxt = S_FETCH;
        else if (ir[12]) state_nxt = S_MEMRD;
        else            state_nxt = S_EXEC;
      end
      S_MEMRD: begin
        mem_rd   = 1'b1;
        addressM = a_reg[PC_W-1:0];
        if (mem_ready) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        alu_x = d_reg;
        alu_y = ir[12] ? mbr : a_reg;
        {zx, nx, zy, ny, f, no} = ir[11:6];
        state_nxt = ir[3] ? S_MEMWR : S_FETCH;
      end
      S_MEMWR: begin
        mem_wr   = 1'b1;
        addressM = wr_addr;
        if (mem_ready) state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      a_reg   <= '0;
      d_reg   <= '0;
      pc_reg  <= '0;
      ir      <= '0;
      mbr     <= '0;
      wr_data <= '0;
      wr_addr <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        S_FETCH: if (run && instr_valid) ir <= instr;
        S_DECODE: begin
          if (!ir[15]) begin
            a_reg  <= {1'b0, ir[14:0]};
            pc_reg <= pc_inc;
          end
        end
        S_MEMRD: if (mem_ready) mbr <= inM;
        S_EXEC: begin
          // jump target and write address use A as it was before this writeback
          if (ir[5]) a_reg <= alu_out;
          if (ir[4]) d_reg <= alu_out;
          if (ir[3]) begin
            wr_data <= alu_out;
            wr_addr <= a_reg[PC_W-1:0];
          end
          pc_reg <= jmp ? a_reg[PC_W-1:0] : pc_inc;
        end
        default: ;
      endcase
    end
  end

endmodule
